// File: rtl/window_pointer_stack.sv
// Register-file window pointer with add/sub wrap detection and a LIFO of
// saved pointers for subroutine call/return. All state moves on the falling clock edge.
module window_pointer_stack #(
  parameter int WP_WIDTH  = 3,
  parameter int OFF_WIDTH = 3,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wp_reset,
  input  logic                 i_wp_add,
  input  logic                 i_wp_sub,
  input  logic                 i_wp_push,
  input  logic                 i_wp_pop,
  input  logic [OFF_WIDTH-1:0] i_offset,
  output logic [WP_WIDTH-1:0]  o_wp_out,
  output logic                 o_wp_wrap,
  output logic [CNT_WIDTH-1:0] o_stack_count,
  output logic                 o_stack_full,
  output logic                 o_stack_empty,
  output logic                 o_stack_err
);

  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WP_WIDTH-1:0]  r_wp;
  logic                 r_wrap;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_err;
  logic [WP_WIDTH-1:0]  r_stack [DEPTH];

  logic [WP_WIDTH-1:0]  w_off_ext;
  logic [WP_WIDTH:0]    w_sum;
  logic [WP_WIDTH:0]    w_diff;
  logic [CNT_WIDTH-1:0] w_cnt_m1;
  logic [IDX_WIDTH-1:0] w_wr_idx;
  logic [IDX_WIDTH-1:0] w_top_idx;
  logic                 w_full;
  logic                 w_empty;
  logic [WP_WIDTH-1:0]  w_wp_nxt;
  logic                 w_wrap_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_err_nxt;
  logic                 w_push_ok;

  // Extra MSB of the sum/difference carries the carry-out / borrow.
  assign w_off_ext = WP_WIDTH'(i_offset);
  assign w_sum     = {1'b0, r_wp} + {1'b0, w_off_ext};
  assign w_diff    = {1'b0, r_wp} - {1'b0, w_off_ext};
  assign w_cnt_m1  = r_count - CNT_WIDTH'(1);
  assign w_wr_idx  = r_count[IDX_WIDTH-1:0];
  assign w_top_idx = w_cnt_m1[IDX_WIDTH-1:0];
  assign w_full    = (r_count == CNT_WIDTH'(DEPTH));
  assign w_empty   = (r_count == CNT_WIDTH'(0));

  // Strobe priority: wp_reset, push+pop, pop, push (with optional add/sub), add/sub.
  always_comb begin
    w_wp_nxt   = r_wp;
    w_wrap_nxt = 1'b0;
    w_cnt_nxt  = r_count;
    w_err_nxt  = r_err;
    w_push_ok  = 1'b0;
    if (i_wp_reset) begin
      w_wp_nxt = '0;
    end else if (i_wp_push && i_wp_pop) begin
      w_err_nxt = 1'b1;
    end else if (i_wp_pop) begin
      if (!w_empty) begin
        w_wp_nxt  = r_stack[w_top_idx];
        w_cnt_nxt = w_cnt_m1;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else begin
      if (i_wp_push) begin
        if (!w_full) begin
          w_push_ok = 1'b1;
          w_cnt_nxt = r_count + CNT_WIDTH'(1);
        end else begin
          w_err_nxt = 1'b1;
        end
      end else begin
        w_push_ok = 1'b0;
      end
      // A failed push does not block the accompanying add/sub.
      if (i_wp_add && i_wp_sub) begin
        w_err_nxt = 1'b1;
      end else if (i_wp_add) begin
        w_wp_nxt   = w_sum[WP_WIDTH-1:0];
        w_wrap_nxt = w_sum[WP_WIDTH];
      end else if (i_wp_sub) begin
        w_wp_nxt   = w_diff[WP_WIDTH-1:0];
        w_wrap_nxt = w_diff[WP_WIDTH];
      end else begin
        w_wp_nxt = r_wp;
      end
    end
  end

  // Architectural state registers.
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      r_wp    <= '0;
      r_wrap  <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wp    <= w_wp_nxt;
      r_wrap  <= w_wrap_nxt;
      r_count <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Saved-pointer storage; contents need no reset because count gates every read.
  always_ff @(negedge i_clk) begin
    if (w_push_ok && !i_reset) begin
      r_stack[w_wr_idx] <= r_wp;
    end
  end

  assign o_wp_out      = r_wp;
  assign o_wp_wrap     = r_wrap;
  assign o_stack_count = r_count;
  assign o_stack_full  = w_full;
  assign o_stack_empty = w_empty;
  assign o_stack_err   = r_err;

endmodule

// File: tb/tb_window_pointer_stack.sv
// Directed bench for window_pointer_stack: drives one strobe set per falling
// edge and compares outputs against hand-computed values 1 ns after the edge.
module tb_window_pointer_stack;

  logic       i_clk = 1'b0;
  logic       i_reset, i_wp_reset, i_wp_add, i_wp_sub, i_wp_push, i_wp_pop;
  logic [2:0] i_offset;
  logic [2:0] o_wp_out;
  logic       o_wp_wrap;
  logic [2:0] o_stack_count;
  logic       o_stack_full, o_stack_empty, o_stack_err;

  int n_checks = 0;
  int n_fail   = 0;

  window_pointer_stack #(.WP_WIDTH(3), .OFF_WIDTH(3), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wp_reset(i_wp_reset),
    .i_wp_add(i_wp_add), .i_wp_sub(i_wp_sub), .i_wp_push(i_wp_push),
    .i_wp_pop(i_wp_pop), .i_offset(i_offset), .o_wp_out(o_wp_out),
    .o_wp_wrap(o_wp_wrap), .o_stack_count(o_stack_count),
    .o_stack_full(o_stack_full), .o_stack_empty(o_stack_empty),
    .o_stack_err(o_stack_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One falling edge with the given strobes (rst, wrst, add, sub, push, pop, offset).
  task automatic step(input logic rst, input logic wrst, input logic add, input logic sub,
                      input logic push, input logic pop, input logic [2:0] off);
    i_reset = rst; i_wp_reset = wrst; i_wp_add = add; i_wp_sub = sub;
    i_wp_push = push; i_wp_pop = pop; i_offset = off;
    @(negedge i_clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] wp, input logic wrap,
                           input logic [2:0] cnt, input logic err);
    check({tag, ".wp"}, 32'(o_wp_out), 32'(wp));
    check({tag, ".wrap"}, 32'(o_wp_wrap), 32'(wrap));
    check({tag, ".cnt"}, 32'(o_stack_count), 32'(cnt));
    check({tag, ".err"}, 32'(o_stack_err), 32'(err));
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk_state("reset", 3'd0, 1'b0, 3'd0, 1'b0);
    check("reset.empty", 32'(o_stack_empty), 32'd1);
    check("reset.full", 32'(o_stack_full), 32'd0);

    // add 3 three times: 3, 6, 1 (carry)
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    chk_state("add1", 3'd3, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    chk_state("add2", 3'd6, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    chk_state("add3", 3'd1, 1'b1, 3'd0, 1'b0);

    // 1 -> 2, then sub 5 borrows to 5, then idle
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
    chk_state("to2", 3'd2, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5);
    chk_state("sub5", 3'd5, 1'b1, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
    chk_state("idle", 3'd5, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
    chk_state("sub_nowrap", 3'd3, 1'b0, 3'd0, 1'b0);

    // wp_reset then wp=1; offset 0 is a no-op add
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4);
    chk_state("wpreset", 3'd0, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    chk_state("add0", 3'd1, 1'b0, 3'd0, 1'b0);

    // nested call/return
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    chk_state("call1", 3'd3, 1'b0, 3'd1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    chk_state("call2", 3'd5, 1'b0, 3'd2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
    chk_state("ret1", 3'd3, 1'b0, 3'd1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    chk_state("ret2", 3'd1, 1'b0, 3'd0, 1'b0);
    check("ret2.empty", 32'(o_stack_empty), 32'd1);

    // overflow: push 1,2,3,4 while incrementing
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    end
    chk_state("fill", 3'd5, 1'b0, 3'd4, 1'b0);
    check("fill.full", 32'(o_stack_full), 32'd1);
    check("fill.empty", 32'(o_stack_empty), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    chk_state("ovf", 3'd6, 1'b0, 3'd4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
      check($sformatf("lifo%0d.wp", k), 32'(o_wp_out), 32'(4 - k));
      check($sformatf("lifo%0d.cnt", k), 32'(o_stack_count), 32'(3 - k));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
    chk_state("udf", 3'd1, 1'b0, 3'd0, 1'b1);

    // push+pop is illegal
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    chk_state("pre_pp", 3'd2, 1'b0, 3'd1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2);
    chk_state("pushpop", 3'd2, 1'b0, 3'd1, 1'b1);

    // add+sub is illegal
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
    chk_state("addsub", 3'd2, 1'b0, 3'd0, 1'b1);

    // wp_reset beats pop; err survives wp_reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    chk_state("two_push", 3'd2, 1'b0, 3'd2, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    chk_state("wprst_pop", 3'd0, 1'b0, 3'd2, 1'b1);

    // reset mid-sequence at count=3, wp=6, err=1
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6);
    chk_state("pre_rst", 3'd6, 1'b0, 3'd3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    chk_state("mid_rst", 3'd0, 1'b0, 3'd0, 1'b0);
    check("mid_rst.empty", 32'(o_stack_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
